alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter RR_INIT, default 0, requester holding priority after reset (0 or 1).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-005 reqN_ready  output  1  arbiter accepts requester N's operation this cycle.
REQ-006 reqN_a, reqN_b  input  32 each  operands A and B.
REQ-007 reqN_ctrl  input  4  operation code, 0..14 per ALU encoding; 15 illegal.
REQ-008 rspN_valid  output  1  result for requester N available.
REQ-009 rspN_ready  input  1  requester N consumes result.
REQ-010 rspN_data  output  32  result value.
REQ-011 rspN_err  output  1  operation had illegal ctrl.
REQ-012 busy  output  1  high whenever FSM not in IDLE.

Function
REQ-013 FSM states IDLE, EXEC, RESP; single operation outstanding at a time.
REQ-014 IDLE: reqN_ready=1 only for the granted requester; grant = requester with valid, ties resolved by priority pointer.
REQ-015 Handshake reqN_valid&reqN_ready latches a, b, ctrl, owner id; IDLE->EXEC next cycle.
REQ-016 EXEC: latched operands drive shared ALU; result registered; EXEC->RESP unconditionally (one cycle).
REQ-017 RESP: rsp{owner}_valid=1, data/err held stable until rsp{owner}_ready; on that edge RESP->IDLE.
REQ-018 Latency: accept edge to rsp_valid high = 2 cycles; minimum accept-to-accept spacing = 3 cycles with rsp_ready tied high.
REQ-019 Priority pointer set to the non-granted requester on every accept; unchanged otherwise.
REQ-020 Ctrl 15: rsp_err=1, rsp_data=0; other ctrl: rsp_err=0, rsp_data=ALU output.
REQ-021 Compare ops (8..13) yield 32-bit 0 or 1, unsigned comparison; shifts use operand B as amount.
REQ-022 Non-owner rsp_valid=0 at all times; both reqN_ready=0 outside IDLE.
REQ-023 Requester withdrawing valid without handshake: no state change, no pointer update.
REQ-024 Inputs sampled only on handshake; operand changes after accept have no effect.

Reset
REQ-025 rst_n low: FSM->IDLE, pointer->RR_INIT, all rsp_valid/err=0, rsp_data=0, busy=0, immediately (asynchronous).
REQ-026 Reset mid-EXEC or mid-RESP discards operation; no response issued after release.
REQ-027 First cycle after release: reqN_ready follows REQ-014 with pointer RR_INIT.

Structure
REQ-028 Shared package holds ALU op-code constants (SLL=0..LHI=14, ILLEGAL=15), data width 32, FSM state enumeration.
REQ-029 Exactly one sub-module: alu, instantiated once, combinational, fed from latched operands.
REQ-030 All outputs driven from registers except reqN_ready (decode of state, pointer, valids).

Verification
REQ-031 Single op: req0 a=5 b=3 ctrl=3, rsp0_ready=1 -> rsp0_valid two cycles after accept, data=8, err=0.
REQ-032 Simultaneous req0,req1 valid, RR_INIT=0 -> req0 granted first, req1 next; third tie grants req0.
REQ-033 Backpressure: req1 a=0xF0 b=0x0F ctrl=5, rsp1_ready low 4 cycles -> data=0xFF held stable, busy=1, no new accept.
REQ-034 Illegal: req0 ctrl=15 -> rsp0_err=1, data=0; next op a=1 b=1 ctrl=8 -> data=1, err=0.
REQ-035 Reset in EXEC: rst_n low one cycle -> all outputs zero immediately; no rsp_valid after release.
REQ-036 Compares: a=2 b=7 ctrl=10 -> 1; ctrl=11 -> 0; ctrl=9 -> 1.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared op codes, widths and FSM states for the ALU arbiter
package alu_arbiter_pkg;

   localparam int DATA_W = 32;
   localparam int CTRL_W = 4;

   localparam logic [CTRL_W-1:0] OP_SLL     = 4'd0;
   localparam logic [CTRL_W-1:0] OP_SRL     = 4'd1;
   localparam logic [CTRL_W-1:0] OP_SRA     = 4'd2;
   localparam logic [CTRL_W-1:0] OP_ADD     = 4'd3;
   localparam logic [CTRL_W-1:0] OP_SUB     = 4'd4;
   localparam logic [CTRL_W-1:0] OP_OR      = 4'd5;
   localparam logic [CTRL_W-1:0] OP_AND     = 4'd6;
   localparam logic [CTRL_W-1:0] OP_XOR     = 4'd7;
   localparam logic [CTRL_W-1:0] OP_SEQ     = 4'd8;
   localparam logic [CTRL_W-1:0] OP_SNE     = 4'd9;
   localparam logic [CTRL_W-1:0] OP_SLT     = 4'd10;
   localparam logic [CTRL_W-1:0] OP_SGT     = 4'd11;
   localparam logic [CTRL_W-1:0] OP_SLE     = 4'd12;
   localparam logic [CTRL_W-1:0] OP_SGE     = 4'd13;
   localparam logic [CTRL_W-1:0] OP_LHI     = 4'd14;
   localparam logic [CTRL_W-1:0] OP_ILLEGAL = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } arbState_t;

   // Turn a single compare outcome into a full-width boolean word.
   function automatic logic [DATA_W-1:0] boolWord(input logic flag);
      return {{(DATA_W-1){1'b0}}, flag};
   endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// rtl/alu_arbiter_alu.sv - combinational shared ALU, unsigned compares, B as shift amount
module alu
   import alu_arbiter_pkg::*;
(
   input  logic [DATA_W-1:0] opA,
   input  logic [DATA_W-1:0] opB,
   input  logic [CTRL_W-1:0] opCtrl,
   output logic [DATA_W-1:0] result
);

   logic [4:0] shiftAmt;

   assign shiftAmt = opB[4:0];

   // Decode the op code into the result; the illegal code yields zero.
   always_comb begin
      result = '0;
      case (opCtrl)
         OP_SLL:  result = opA << shiftAmt;
         OP_SRL:  result = opA >> shiftAmt;
         OP_SRA:  result = $unsigned($signed(opA) >>> shiftAmt);
         OP_ADD:  result = opA + opB;
         OP_SUB:  result = opA - opB;
         OP_OR:   result = opA | opB;
         OP_AND:  result = opA & opB;
         OP_XOR:  result = opA ^ opB;
         OP_SEQ:  result = boolWord(opA == opB);
         OP_SNE:  result = boolWord(opA != opB);
         OP_SLT:  result = boolWord(opA <  opB);
         OP_SGT:  result = boolWord(opA >  opB);
         OP_SLE:  result = boolWord(opA <= opB);
         OP_SGE:  result = boolWord(opA >= opB);
         OP_LHI:  result = {opB[15:0], 16'h0000};
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end to one shared ALU
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter bit RR_INIT = 1'b0
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [CTRL_W-1:0] req0_ctrl,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [CTRL_W-1:0] req1_ctrl,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic [DATA_W-1:0] rsp0_data,
   output logic              rsp0_err,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DATA_W-1:0] rsp1_data,
   output logic              rsp1_err,
   output logic              busy
);

   arbState_t         state;
   logic              prioPtr;
   logic              owner;
   logic [DATA_W-1:0] latA;
   logic [DATA_W-1:0] latB;
   logic [CTRL_W-1:0] latCtrl;
   logic [DATA_W-1:0] aluResult;
   logic              grant0;
   logic              grant1;
   logic              ownerTaken;

   // A requester wins if it is alone or holds the priority pointer.
   assign grant0 = req0_valid & (~req1_valid | ~prioPtr);
   assign grant1 = req1_valid & (~req0_valid |  prioPtr);

   assign req0_ready = (state == ST_IDLE) & grant0;
   assign req1_ready = (state == ST_IDLE) & grant1;

   assign ownerTaken = owner ? rsp1_ready : rsp0_ready;

   alu uAlu (
      .opA    (latA),
      .opB    (latB),
      .opCtrl (latCtrl),
      .result (aluResult)
   );

   // Accept one operation, compute it for one cycle, then hold the response until consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         prioPtr    <= RR_INIT;
         owner      <= 1'b0;
         latA       <= '0;
         latB       <= '0;
         latCtrl    <= '0;
         rsp0_valid <= 1'b0;
         rsp0_data  <= '0;
         rsp0_err   <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp1_data  <= '0;
         rsp1_err   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req0_ready) begin
                  latA    <= req0_a;
                  latB    <= req0_b;
                  latCtrl <= req0_ctrl;
                  owner   <= 1'b0;
                  prioPtr <= 1'b1;
                  state   <= ST_EXEC;
                  busy    <= 1'b1;
               end else if (req1_ready) begin
                  latA    <= req1_a;
                  latB    <= req1_b;
                  latCtrl <= req1_ctrl;
                  owner   <= 1'b1;
                  prioPtr <= 1'b0;
                  state   <= ST_EXEC;
                  busy    <= 1'b1;
               end
            end
            ST_EXEC: begin
               if (owner) begin
                  rsp1_valid <= 1'b1;
                  rsp1_err   <= (latCtrl == OP_ILLEGAL);
                  rsp1_data  <= (latCtrl == OP_ILLEGAL) ? '0 : aluResult;
               end else begin
                  rsp0_valid <= 1'b1;
                  rsp0_err   <= (latCtrl == OP_ILLEGAL);
                  rsp0_data  <= (latCtrl == OP_ILLEGAL) ? '0 : aluResult;
               end
               state <= ST_RESP;
            end
            ST_RESP: begin
               if (ownerTaken) begin
                  rsp0_valid <= 1'b0;
                  rsp1_valid <= 1'b0;
                  state      <= ST_IDLE;
                  busy       <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized and directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [3:0]  req0_ctrl = '0, req1_ctrl = '0;
   logic        rsp0_valid, rsp1_valid;
   logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
   logic [31:0] rsp0_data, rsp1_data;
   logic        rsp0_err, rsp1_err;
   logic        busy;

   int errCount = 0;
   int checkCount = 0;

   // transaction-level reference state
   bit          mOut;
   int          mAge;
   bit          mOwner;
   bit          mPtr;
   logic [31:0] mData;
   bit          mErr;

   alu_arbiter #(.RR_INIT(1'b0)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errCount++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] refAlu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
      longint unsigned pw;
      int sh;
      sh = int'(b % 32);
      pw = 64'd1 << sh;
      case (c)
         4'd0:  return 32'((longint'(a) * pw) % 64'h1_0000_0000);
         4'd1:  return a / 32'(pw);
         4'd2:  return (a[31] == 1'b0) ? a / 32'(pw) : ~((~a) / 32'(pw));
         4'd3:  return 32'(longint'(a) + longint'(b));
         4'd4:  return 32'(longint'(a) + 64'h1_0000_0000 - longint'(b));
         4'd5:  return a | b;
         4'd6:  return a & b;
         4'd7:  return a ^ b;
         4'd8:  return (a == b) ? 32'd1 : 32'd0;
         4'd9:  return (a != b) ? 32'd1 : 32'd0;
         4'd10: return (a <  b) ? 32'd1 : 32'd0;
         4'd11: return (a >  b) ? 32'd1 : 32'd0;
         4'd12: return (a <= b) ? 32'd1 : 32'd0;
         4'd13: return (a >= b) ? 32'd1 : 32'd0;
         4'd14: return (b % 32'h1_0000) * 32'h1_0000;
         default: return 32'd0;
      endcase
   endfunction

   task automatic modelReset();
      mOut = 0; mAge = 0; mOwner = 0; mPtr = 0; mData = '0; mErr = 0;
   endtask

   // One clock cycle: drive at the falling edge, check 1 time unit later, advance the model.
   task automatic doCycle(input bit v0, input bit v1,
                          input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] c0,
                          input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] c1,
                          input bit r0, input bit r1);
      bit expRdy0, expRdy1, expV0, expV1;
      @(negedge clk);
      req0_valid = v0; req0_a = a0; req0_b = b0; req0_ctrl = c0;
      req1_valid = v1; req1_a = a1; req1_b = b1; req1_ctrl = c1;
      rsp0_ready = r0; rsp1_ready = r1;
      #1;
      expRdy0 = !mOut && v0 && (!v1 || mPtr == 1'b0);
      expRdy1 = !mOut && v1 && (!v0 || mPtr == 1'b1);
      expV0 = mOut && mAge >= 2 && mOwner == 1'b0;
      expV1 = mOut && mAge >= 2 && mOwner == 1'b1;
      checkVal("req0_ready", 32'(req0_ready), 32'(expRdy0));
      checkVal("req1_ready", 32'(req1_ready), 32'(expRdy1));
      checkVal("rsp0_valid", 32'(rsp0_valid), 32'(expV0));
      checkVal("rsp1_valid", 32'(rsp1_valid), 32'(expV1));
      checkVal("busy", 32'(busy), 32'(mOut));
      if (expV0) begin
         checkVal("rsp0_data", rsp0_data, mData);
         checkVal("rsp0_err", 32'(rsp0_err), 32'(mErr));
      end
      if (expV1) begin
         checkVal("rsp1_data", rsp1_data, mData);
         checkVal("rsp1_err", 32'(rsp1_err), 32'(mErr));
      end
      if (mOut) begin
         if (mAge >= 2 && (mOwner ? r1 : r0)) mOut = 0;
         else if (mAge < 2) mAge++;
      end else if (expRdy0 || expRdy1) begin
         mOut = 1; mAge = 1; mOwner = expRdy1;
         mData = expRdy1 ? refAlu(a1, b1, c1) : refAlu(a0, b0, c0);
         mErr  = expRdy1 ? (c1 == 4'd15) : (c0 == 4'd15);
         if (mErr) mData = '0;
         mPtr = ~mOwner;
      end
   endtask

   task automatic idleCycle();
      doCycle(0, 0, '0, '0, '0, '0, '0, '0, 1, 1);
   endtask

   task automatic applyReset();
      @(negedge clk);
      req0_valid = 0; req1_valid = 0;
      rst_n = 1'b0;
      #1;
      checkVal("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
      checkVal("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
      checkVal("rst_rsp0_data", rsp0_data, 32'd0);
      checkVal("rst_rsp1_data", rsp1_data, 32'd0);
      checkVal("rst_err", 32'({rsp0_err, rsp1_err}), 32'd0);
      checkVal("rst_busy", 32'(busy), 32'd0);
      checkVal("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
      modelReset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      modelReset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      applyReset();

      // ties from reset: req0, then req1, then req0
      doCycle(1, 1, 32'd1, 32'd2, 4'd3, 32'd10, 32'd20, 4'd3, 1, 1);
      checkVal("tie1_grant0", 32'({req0_ready, req1_ready}), 32'b10);
      repeat (2) doCycle(1, 1, 32'd1, 32'd2, 4'd3, 32'd10, 32'd20, 4'd3, 1, 1);
      doCycle(1, 1, 32'd1, 32'd2, 4'd3, 32'd10, 32'd20, 4'd3, 1, 1);
      checkVal("tie2_grant1", 32'({req0_ready, req1_ready}), 32'b01);
      repeat (2) doCycle(1, 1, 32'd1, 32'd2, 4'd3, 32'd10, 32'd20, 4'd3, 1, 1);
      doCycle(1, 1, 32'd1, 32'd2, 4'd3, 32'd10, 32'd20, 4'd3, 1, 1);
      checkVal("tie3_grant0", 32'({req0_ready, req1_ready}), 32'b10);
      repeat (2) idleCycle();

      // single add, response two cycles after accept
      doCycle(1, 0, 32'd5, 32'd3, 4'd3, '0, '0, '0, 1, 1);
      idleCycle();
      idleCycle();
      checkVal("add_valid", 32'(rsp0_valid), 32'd1);
      checkVal("add_data", rsp0_data, 32'd8);
      checkVal("add_err", 32'(rsp0_err), 32'd0);

      // backpressure on requester 1 while requester 0 waits
      doCycle(0, 1, '0, '0, '0, 32'hF0, 32'h0F, 4'd5, 1, 0);
      doCycle(1, 0, 32'd9, 32'd9, 4'd3, '0, '0, '0, 1, 0);
      for (int i = 0; i < 4; i++) begin
         doCycle(1, 0, 32'd9, 32'd9, 4'd3, '0, '0, '0, 1, 0);
         checkVal("bp_data", rsp1_data, 32'hFF);
         checkVal("bp_busy", 32'(busy), 32'd1);
         checkVal("bp_noaccept", 32'(req0_ready), 32'd0);
      end
      doCycle(0, 0, '0, '0, '0, '0, '0, '0, 1, 1);
      idleCycle();

      // illegal op then equality compare
      doCycle(1, 0, 32'h1234, 32'h5678, 4'd15, '0, '0, '0, 1, 1);
      idleCycle();
      idleCycle();
      checkVal("ill_err", 32'(rsp0_err), 32'd1);
      checkVal("ill_data", rsp0_data, 32'd0);
      doCycle(1, 0, 32'd1, 32'd1, 4'd8, '0, '0, '0, 1, 1);
      idleCycle();
      idleCycle();
      checkVal("seq_data", rsp0_data, 32'd1);
      checkVal("seq_err", 32'(rsp0_err), 32'd0);

      // unsigned compares
      doCycle(1, 0, 32'd2, 32'd7, 4'd10, '0, '0, '0, 1, 1);
      idleCycle(); idleCycle();
      checkVal("slt_data", rsp0_data, 32'd1);
      doCycle(1, 0, 32'd2, 32'd7, 4'd11, '0, '0, '0, 1, 1);
      idleCycle(); idleCycle();
      checkVal("sgt_data", rsp0_data, 32'd0);
      doCycle(1, 0, 32'd2, 32'd7, 4'd9, '0, '0, '0, 1, 1);
      idleCycle(); idleCycle();
      checkVal("sne_data", rsp0_data, 32'd1);

      // reset while executing discards the operation
      doCycle(0, 1, '0, '0, '0, 32'd4, 32'd4, 4'd3, 1, 1);
      applyReset();
      repeat (4) idleCycle();
      checkVal("post_rst_rsp1", 32'(rsp1_valid), 32'd0);

      // randomized traffic with occasional resets
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] a0, b0, a1, b1;
         a0 = $urandom; b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
         a1 = $urandom_range(0, 15); b1 = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 40);
         if ($urandom_range(0, 299) == 0) applyReset();
         else doCycle($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6,
                      a0, b0, 4'($urandom_range(0, 15)),
                      a1, b1, 4'($urandom_range(0, 15)),
                      $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      end

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
